// File: rtl/fetch_pkg.sv
// Shared decode helpers for the IF-stage predictor: opcodes, link-register test,
// immediate extraction and 2-bit counter encodings.
package fetch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [1:0] {
        CF_NONE,
        CF_BRANCH,
        CF_JAL,
        CF_JALR
    } cf_kind_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Compressed encodings (low bits != 2'b11) are never treated as control flow.
    function automatic cf_kind_e decode_kind(input logic [31:0] i);
        cf_kind_e k;
        k = CF_NONE;
        if (i[1:0] == 2'b11) begin
            case (i[6:0])
                OP_BRANCH: k = CF_BRANCH;
                OP_JAL:    k = CF_JAL;
                OP_JALR:   k = CF_JALR;
                default:   k = CF_NONE;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/fetch_predictor_if.sv
// Fetch-side bundle: the fetched word, the RAS top-of-stack, and the resulting
// prediction plus RAS push/pop controls.
interface fetch_predictor_if;
    logic        instr_valid_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        ras_valid_i;
    logic [31:0] ras_addr_i;
    logic        ras_push_o;
    logic        ras_pop_o;
    logic [31:0] ras_addr_o;
    logic        pred_taken_o;
    logic [31:0] pred_pc_o;

    modport master (
        output instr_valid_i, pc_i, instr_i, ras_valid_i, ras_addr_i,
        input  ras_push_o, ras_pop_o, ras_addr_o, pred_taken_o, pred_pc_o
    );

    modport slave (
        input  instr_valid_i, pc_i, instr_i, ras_valid_i, ras_addr_i,
        output ras_push_o, ras_pop_o, ras_addr_o, pred_taken_o, pred_pc_o
    );
endinterface

// File: rtl/fetch_predictor_bht_2bit.sv
// Branch history table of saturating 2-bit counters: combinational read,
// synchronous saturating update, no write-to-read bypass.
module bht_2bit
    import fetch_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int BHT_IDX_W   = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BHT_IDX_W-1:0] rd_idx,
    output logic [1:0]           rd_cnt,
    input  logic                 upd_valid,
    input  logic [BHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken
);

    logic [1:0] cnt_q [BHT_ENTRIES];

    assign rd_cnt = cnt_q[rd_idx];

    // NOTE: the table must come out of reset weakly not-taken, so it is built
    // from resettable flops rather than an unreset RAM; <= keeps the read port
    // seeing the pre-edge value during a same-cycle update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i] <= WNT;
            end
        end else if (upd_valid) begin
            if (upd_taken && cnt_q[upd_idx] != ST) begin
                cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'd1;
            end else if (!upd_taken && cnt_q[upd_idx] != SNT) begin
                cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_predictor.sv
// IF-stage next-PC predictor: decodes the fetched word, predicts branches from
// the BHT, returns from the RAS, and drives RAS push/pop controls.
module fetch_predictor
    import fetch_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int BHT_IDX_W   = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    fetch_predictor_if.slave  fif,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic              upd_taken_i,
    output logic [31:0]       pred_cnt_o
);

    cf_kind_e    kind;
    logic [1:0]  bht_cnt;
    logic [4:0]  rd, rs1;
    logic        rd_link, rs1_link;
    logic        push_raw, pop_raw, taken_raw;
    logic        act, pred_taken;
    logic [31:0] seq_pc, target;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{upd_pc_i[31:BHT_IDX_W+2], upd_pc_i[1:0], fif.ras_addr_i[0]};

    bht_2bit #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .BHT_IDX_W   (BHT_IDX_W)
    ) u_bht (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx    (fif.pc_i[BHT_IDX_W+1:2]),
        .rd_cnt    (bht_cnt),
        .upd_valid (upd_valid_i),
        .upd_idx   (upd_pc_i[BHT_IDX_W+1:2]),
        .upd_taken (upd_taken_i)
    );

    assign kind     = decode_kind(fif.instr_i);
    assign rd       = fif.instr_i[11:7];
    assign rs1      = fif.instr_i[19:15];
    assign rd_link  = is_link(rd);
    assign rs1_link = is_link(rs1);
    assign seq_pc   = fif.pc_i + 32'd4;

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        push_raw  = 1'b0;
        pop_raw   = 1'b0;
        taken_raw = 1'b0;
        target    = seq_pc;
        case (kind)
            CF_BRANCH: begin
                taken_raw = bht_cnt[1];
                target    = fif.pc_i + imm_b(fif.instr_i);
            end
            CF_JAL: begin
                taken_raw = 1'b1;
                target    = fif.pc_i + imm_j(fif.instr_i);
                push_raw  = rd_link;
            end
            CF_JALR: begin
                // Return-hint table: a link rs1 pops unless rd names the same link.
                push_raw = rd_link;
                pop_raw  = rs1_link && !(rd_link && rd == rs1);
                if (pop_raw && fif.ras_valid_i) begin
                    taken_raw = 1'b1;
                    target    = {fif.ras_addr_i[31:1], 1'b0};
                end
            end
            default: ;
        endcase
    end

    // Prediction ignores stall so the PC mux sees a stable choice while IF is held.
    assign act        = fif.instr_valid_i & ~stall_i & ~flush_i;
    assign pred_taken = fif.instr_valid_i & ~flush_i & taken_raw;

    assign fif.ras_push_o   = act & push_raw;
    assign fif.ras_pop_o    = act & pop_raw;
    assign fif.ras_addr_o   = seq_pc;
    assign fif.pred_taken_o = pred_taken;
    assign fif.pred_pc_o    = pred_taken ? target : seq_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_cnt_o <= '0;
        end else if (act && pred_taken) begin
            pred_cnt_o <= pred_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_predictor.sv
// Self-checking bench for fetch_predictor: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_fetch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        upd_valid, upd_taken;
    logic [31:0] upd_pc;
    logic [31:0] pred_cnt;

    fetch_predictor_if fif ();

    fetch_predictor #(
        .BHT_ENTRIES (64),
        .BHT_IDX_W   (6)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .flush_i     (flush),
        .fif         (fif),
        .upd_valid_i (upd_valid),
        .upd_pc_i    (upd_pc),
        .upd_taken_i (upd_taken),
        .pred_cnt_o  (pred_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          bht_m [64];
    logic [31:0] cnt_m;

    function automatic void predict(output bit push, output bit pop,
                                    output bit taken, output logic [31:0] npc);
        logic [31:0] i, pc, seq, tgt;
        int op, rd, rs1, off;
        bit rdl, rsl, vis, act, want_push, want_pop, tk;
        i   = fif.instr_i;
        pc  = fif.pc_i;
        seq = pc + 32'd4;
        tgt = seq;
        op  = int'(i[6:0]);
        rd  = int'(i[11:7]);
        rs1 = int'(i[19:15]);
        rdl = (rd == 1) || (rd == 5);
        rsl = (rs1 == 1) || (rs1 == 5);
        vis = fif.instr_valid_i && !flush;
        act = vis && !stall;
        want_push = 0;
        want_pop  = 0;
        tk        = 0;
        if (i[1:0] == 2'b11) begin
            if (op == 'h63) begin
                off = -4096 * int'(i[31]) + 2048 * int'(i[7]) + 32 * int'(i[30:25]) + 2 * int'(i[11:8]);
                tk  = bht_m[int'((pc >> 2) % 64)] >= 2;
                tgt = pc + 32'(off);
            end else if (op == 'h6F) begin
                off = -(1 << 20) * int'(i[31]) + (1 << 12) * int'(i[19:12])
                      + 2048 * int'(i[20]) + 2 * int'(i[30:21]);
                tk  = 1;
                tgt = pc + 32'(off);
                want_push = rdl;
            end else if (op == 'h67) begin
                want_push = rdl;
                want_pop  = rsl && !(rdl && rd == rs1);
                if (want_pop && fif.ras_valid_i) begin
                    tk  = 1;
                    tgt = fif.ras_addr_i & ~32'd1;
                end
            end
        end
        push  = act && want_push;
        pop   = act && want_pop;
        taken = vis && tk;
        npc   = taken ? tgt : seq;
    endfunction

    always @(posedge clk or posedge rst) begin : model_upd
        bit m_push, m_pop, m_taken;
        logic [31:0] m_npc;
        int idx;
        if (rst) begin
            for (int k = 0; k < 64; k++) bht_m[k] = 1;
            cnt_m = 0;
        end else begin
            predict(m_push, m_pop, m_taken, m_npc);
            if (m_taken && !stall) cnt_m = cnt_m + 1;
            if (upd_valid) begin
                idx = int'((upd_pc >> 2) % 64);
                if (upd_taken) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
                else           bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit c_push, c_pop, c_taken;
        logic [31:0] c_npc;
        if (chk_en) begin
            predict(c_push, c_pop, c_taken, c_npc);
            check("model.ras_push",   32'(fif.ras_push_o),   32'(c_push));
            check("model.ras_pop",    32'(fif.ras_pop_o),    32'(c_pop));
            check("model.pred_taken", 32'(fif.pred_taken_o), 32'(c_taken));
            check("model.pred_pc",    fif.pred_pc_o,         c_npc);
            check("model.ras_addr",   fif.ras_addr_o,        fif.pc_i + 32'd4);
            check("model.pred_cnt",   pred_cnt,              cnt_m);
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        fif.instr_valid_i = 1'b0;
        fif.pc_i          = 32'h0;
        fif.instr_i       = 32'h13;
        fif.ras_valid_i   = 1'b0;
        fif.ras_addr_i    = 32'h0;
        stall             = 1'b0;
        flush             = 1'b0;
        upd_valid         = 1'b0;
        upd_pc            = 32'h0;
        upd_taken         = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        fif.instr_valid_i = 1'b1;
        fif.pc_i          = pc;
        fif.instr_i       = instr;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
    endtask

    localparam logic [31:0] BEQ_P16  = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] JAL_RA   = 32'h0400_00EF;  // jal x1,+0x40
    localparam logic [31:0] JAL_BACK = 32'hFF9F_F06F;  // jal x0,-8
    localparam logic [31:0] RET      = 32'h0000_8067;  // jalr x0,0(x1)
    localparam logic [31:0] JALR_51  = 32'h0000_82E7;  // jalr x5,0(x1)
    localparam logic [31:0] JALR_11  = 32'h0000_80E7;  // jalr x1,0(x1)

    initial begin
        idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        smp();
        check("reset.pred_cnt", pred_cnt, 32'h0);
        check("reset.no_push", 32'(fif.ras_push_o), 32'h0);
        nxt();
        rst = 1'b0;

        // Fresh counter is weakly not-taken.
        fetch(32'h100, BEQ_P16);
        smp();
        check("t1.taken", 32'(fif.pred_taken_o), 32'h0);
        check("t1.pc",    fif.pred_pc_o,         32'h104);

        // Train to strongly taken, then back down past zero.
        nxt(); idle(); upd(32'h100, 1'b1);
        nxt(); upd(32'h100, 1'b1);
        nxt(); idle(); fetch(32'h100, BEQ_P16);
        smp();
        check("t2.taken", 32'(fif.pred_taken_o), 32'h1);
        check("t2.pc",    fif.pred_pc_o,         32'h110);
        for (int k = 0; k < 3; k++) begin
            nxt(); idle(); upd(32'h100, 1'b0);
        end
        nxt(); idle(); fetch(32'h100, BEQ_P16);
        smp();
        check("t2.sat0.pc", fif.pred_pc_o, 32'h104);
        nxt(); upd(32'h100, 1'b1);
        smp();
        check("t2.sat0.same_cycle", 32'(fif.pred_taken_o), 32'h0);
        nxt(); upd_valid = 1'b0;
        smp();
        check("t2.from00.taken", 32'(fif.pred_taken_o), 32'h0);

        // JAL call pushes the link address; stall drops only the RAS side effect.
        nxt(); idle(); fetch(32'h200, JAL_RA);
        smp();
        check("t3.push",     32'(fif.ras_push_o), 32'h1);
        check("t3.ras_addr", fif.ras_addr_o,      32'h204);
        check("t3.pc",       fif.pred_pc_o,       32'h240);
        nxt(); stall = 1'b1;
        smp();
        check("t3.stall.push",  32'(fif.ras_push_o),   32'h0);
        check("t3.stall.taken", 32'(fif.pred_taken_o), 32'h1);
        check("t3.stall.pc",    fif.pred_pc_o,         32'h240);

        // Returns.
        nxt(); idle(); fetch(32'h300, RET);
        fif.ras_valid_i = 1'b1; fif.ras_addr_i = 32'h204;
        smp();
        check("t4.pop", 32'(fif.ras_pop_o), 32'h1);
        check("t4.pc",  fif.pred_pc_o,      32'h204);
        nxt(); fif.ras_addr_i = 32'hA05;
        smp();
        check("t4.lsb_cleared", fif.pred_pc_o, 32'hA04);
        nxt(); fif.ras_valid_i = 1'b0;
        smp();
        check("t4.inv.pop",   32'(fif.ras_pop_o),    32'h1);
        check("t4.inv.taken", 32'(fif.pred_taken_o), 32'h0);
        check("t4.inv.pc",    fif.pred_pc_o,         32'h304);

        // Link-register hint combinations.
        nxt(); fif.instr_i = JALR_51; fif.ras_valid_i = 1'b1;
        smp();
        check("t5.x5x1.push", 32'(fif.ras_push_o), 32'h1);
        check("t5.x5x1.pop",  32'(fif.ras_pop_o),  32'h1);
        nxt(); fif.instr_i = JALR_11;
        smp();
        check("t5.x1x1.push", 32'(fif.ras_push_o), 32'h1);
        check("t5.x1x1.pop",  32'(fif.ras_pop_o),  32'h0);
        check("t5.x1x1.pc",   fif.pred_pc_o,       32'h304);
        nxt(); fif.instr_i = JALR_51; flush = 1'b1;
        smp();
        check("t5.flush.push", 32'(fif.ras_push_o), 32'h0);
        check("t5.flush.pop",  32'(fif.ras_pop_o),  32'h0);
        nxt(); fif.instr_i = JALR_11;
        smp();
        check("t5.flush.x1x1.push", 32'(fif.ras_push_o), 32'h0);

        // Backward jump, non-control word, PC wrap.
        nxt(); idle(); fetch(32'h400, JAL_BACK);
        smp();
        check("x.jal_back.pc",   fif.pred_pc_o,       32'h3F8);
        check("x.jal_back.push", 32'(fif.ras_push_o), 32'h0);
        nxt(); fetch(32'h200, 32'h0400_00EC);
        smp();
        check("x.rvc.pc", fif.pred_pc_o, 32'h204);
        nxt(); fetch(32'hFFFF_FFFC, 32'h13);
        smp();
        check("x.wrap.pc", fif.pred_pc_o, 32'h0);

        // Same-cycle update and read of one index.
        nxt(); fetch(32'h180, BEQ_P16); upd(32'h180, 1'b1);
        smp();
        check("t6.same.taken", 32'(fif.pred_taken_o), 32'h0);
        nxt(); upd_valid = 1'b0;
        smp();
        check("t6.next.taken", 32'(fif.pred_taken_o), 32'h1);
        check("t6.next.pc",    fif.pred_pc_o,         32'h190);
        nxt();
        check("t6.pred_cnt_before_rst", pred_cnt, 32'd7);

        // Reset mid-run.
        idle(); rst = 1'b1;
        smp();
        check("t6.rst.pred_cnt", pred_cnt, 32'h0);
        nxt(); rst = 1'b0; fetch(32'h180, BEQ_P16);
        smp();
        check("t6.rst.taken", 32'(fif.pred_taken_o), 32'h0);
        nxt(); upd(32'h180, 1'b1);
        nxt(); upd_valid = 1'b0;
        smp();
        check("t6.rst.retrain", 32'(fif.pred_taken_o), 32'h1);

        nxt(); idle();
        smp();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
